// File: rtl/game_ctrl_core.sv
// Board-flipping puzzle controller: button conditioning, board load (preset/random),
// move application, step counting and win/loss detection.
module game_ctrl_core #(
  parameter int unsigned ROWS      = 3,
  parameter int unsigned COLS      = 4,
  parameter int unsigned BSEL_W    = 5,
  parameter int unsigned STEP_W    = 6,
  parameter int unsigned MAX_STEPS = 0
) (
  input  logic                    clk_d,
  input  logic                    rst,
  input  logic [BSEL_W-1:0]       board_num_sw,
  input  logic                    start_sw,
  input  logic                    reset_bt,
  input  logic [COLS-1:0]         act_bt,
  input  logic                    random_bt,
  input  logic [ROWS*COLS-1:0]    preset_board,
  output logic [BSEL_W-1:0]       board_sel,
  output logic [ROWS*COLS-1:0]    out,
  output logic [1:0]              game_status,
  output logic [STEP_W-1:0]       step_count,
  output logic                    win_led,
  output logic                    lose_led,
  output logic [BSEL_W-1:0]       board_num_led,
  output logic                    start_led
);

  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned NBT    = COLS + 2;
  localparam int unsigned LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 32'hACE1_0001;
  localparam logic [STEP_W-1:0] MAX_S     = STEP_W'(MAX_STEPS);

  localparam logic [1:0] ST_CHOOSE = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_WON    = 2'd2;
  localparam logic [1:0] ST_LOST   = 2'd3;

  typedef enum logic [2:0] {
    S_CHOOSE = 3'd0,
    S_INIT   = 3'd1,
    S_PLAY   = 3'd2,
    S_WON    = 3'd3,
    S_LOST   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [NBT-1:0]      sync1_q, sync1_d;
  logic [NBT-1:0]      sync2_q, sync2_d;
  logic [NBT-1:0]      prev_q, prev_d;
  logic [NBT-1:0]      pulse_q, pulse_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CELLS-1:0]    cur_q, cur_d;
  logic [CELLS-1:0]    start_board_q, start_board_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                rnd_hold_q, rnd_hold_d;
  logic [BSEL_W-1:0]   board_sel_q, board_sel_d;
  logic                start_led_q, start_led_d;
  logic [1:0]          status_q, status_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;

  logic [COLS-1:0]     act_p;
  logic [COLS-1:0]     act_low;
  logic                rst_p;
  logic                rnd_p;
  logic [CELLS-1:0]    flip;
  logic [CELLS-1:0]    cur_mv;
  logic [CELLS-1:0]    rnd_board;
  logic [STEP_W-1:0]   step_inc;

  // Cells toggled by action k: columns k-1..k+1 of every row, no wrap.
  function automatic logic [CELLS-1:0] col_mask(input int k);
    logic [CELLS-1:0] m;
    m = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if ((c >= k - 1) && (c <= k + 1)) begin
          m = m | (CELLS'(1) << (r * int'(COLS) + c));
        end
      end
    end
    return m;
  endfunction

  always_comb begin
    sync1_d       = {random_bt, reset_bt, act_bt};
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    pulse_d       = sync2_q & ~prev_q;
    lfsr_d        = {lfsr_q[LFSR_W-2:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    board_sel_d   = board_num_sw;
    start_led_d   = start_sw;
    state_d       = state_q;
    cur_d         = cur_q;
    start_board_d = start_board_q;
    step_d        = step_q;
    rnd_hold_d    = rnd_hold_q;

    act_p   = pulse_q[COLS-1:0];
    rst_p   = pulse_q[COLS];
    rnd_p   = pulse_q[COLS+1];
    // Lowest-index action wins when several arrive together.
    act_low = act_p & (~act_p + COLS'(1));
    flip    = '0;
    for (int k = 0; k < int'(COLS); k++) begin
      if (act_low[k]) flip = flip | col_mask(k);
    end
    cur_mv    = cur_q ^ flip;
    step_inc  = (step_q == '1) ? step_q : step_q + STEP_W'(1);
    rnd_board = lfsr_q[CELLS-1:0];
    if (rnd_board == '0) rnd_board[0] = 1'b1;

    case (state_q)
      S_CHOOSE: begin
        step_d = '0;
        if (!rnd_hold_q) cur_d = preset_board;
        if (rnd_p) begin
          cur_d      = rnd_board;
          rnd_hold_d = 1'b1;
        end
        if (board_sel_d != board_sel_q) rnd_hold_d = 1'b0;
        if (start_led_q) state_d = S_INIT;
      end
      S_INIT: begin
        start_board_d = cur_q;
        step_d        = '0;
        state_d       = S_PLAY;
      end
      S_PLAY: begin
        if (rst_p) begin
          cur_d  = start_board_q;
          step_d = '0;
        end else if (act_p != '0) begin
          cur_d  = cur_mv;
          step_d = step_inc;
          if (cur_mv == '0) begin
            state_d = S_WON;
          end else if ((MAX_STEPS != 0) && (step_inc == MAX_S)) begin
            state_d = S_LOST;
          end
        end
      end
      S_WON, S_LOST: begin
        // Restore the board here so INIT re-captures the original start board.
        if (rst_p) begin
          cur_d   = start_board_q;
          step_d  = '0;
          state_d = S_INIT;
        end
      end
      default: state_d = S_CHOOSE;
    endcase

    if ((state_q != S_CHOOSE) && !start_led_q) begin
      state_d    = S_CHOOSE;
      rnd_hold_d = 1'b0;
      cur_d      = cur_q;
      step_d     = '0;
    end

    case (state_d)
      S_INIT, S_PLAY: status_d = ST_PLAY;
      S_WON:          status_d = ST_WON;
      S_LOST:         status_d = ST_LOST;
      default:        status_d = ST_CHOOSE;
    endcase
    win_d  = (state_d == S_WON);
    lose_d = (state_d == S_LOST);
  end

  always_ff @(posedge clk_d) begin
    if (rst) begin
      state_q       <= S_CHOOSE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      pulse_q       <= '0;
      lfsr_q        <= LFSR_SEED;
      cur_q         <= '0;
      start_board_q <= '0;
      step_q        <= '0;
      rnd_hold_q    <= 1'b0;
      board_sel_q   <= '0;
      start_led_q   <= 1'b0;
      status_q      <= ST_CHOOSE;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      pulse_q       <= pulse_d;
      lfsr_q        <= lfsr_d;
      cur_q         <= cur_d;
      start_board_q <= start_board_d;
      step_q        <= step_d;
      rnd_hold_q    <= rnd_hold_d;
      board_sel_q   <= board_sel_d;
      start_led_q   <= start_led_d;
      status_q      <= status_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
    end
  end

  assign board_sel     = board_sel_q;
  assign board_num_led = board_sel_q;
  assign out           = cur_q;
  assign game_status   = status_q;
  assign step_count    = step_q;
  assign win_led       = win_q;
  assign lose_led      = lose_q;
  assign start_led     = start_led_q;

endmodule

// File: tb/tb_game_ctrl_core.sv
// Randomized self-checking bench for game_ctrl_core against a move-level reference model.
module tb_game_ctrl_core;

  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int MAXS = 2;
  localparam int SMAX = 63;

  logic        clk_d = 1'b0;
  logic        rst;
  logic [4:0]  board_num_sw;
  logic        start_sw;
  logic        reset_bt;
  logic [3:0]  act_bt;
  logic        random_bt;
  logic [11:0] preset_board;
  logic [4:0]  board_sel;
  logic [11:0] out;
  logic [1:0]  game_status;
  logic [5:0]  step_count;
  logic        win_led;
  logic        lose_led;
  logic [4:0]  board_num_led;
  logic        start_led;

  logic [11:0] rom [32];
  logic [31:0] tb_lfsr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [11:0] m_cur;
  logic [11:0] m_start;
  int          m_step;
  int          m_stat;

  game_ctrl_core #(
    .ROWS(ROWS), .COLS(COLS), .BSEL_W(5), .STEP_W(6), .MAX_STEPS(MAXS)
  ) dut (
    .clk_d(clk_d), .rst(rst), .board_num_sw(board_num_sw), .start_sw(start_sw),
    .reset_bt(reset_bt), .act_bt(act_bt), .random_bt(random_bt),
    .preset_board(preset_board), .board_sel(board_sel), .out(out),
    .game_status(game_status), .step_count(step_count), .win_led(win_led),
    .lose_led(lose_led), .board_num_led(board_num_led), .start_led(start_led)
  );

  always #5 clk_d = ~clk_d;

  assign preset_board = rom[board_sel];

  // Free-running reference LFSR, taps 32,22,2,1
  always @(posedge clk_d) begin
    if (rst) tb_lfsr <= 32'hACE1_0001;
    else     tb_lfsr <= {tb_lfsr[30:0], tb_lfsr[31] ^ tb_lfsr[21] ^ tb_lfsr[1] ^ tb_lfsr[0]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},  32'(out), 32'(m_cur));
    check({tag, ".stat"}, 32'(game_status), 32'(m_stat));
    check({tag, ".step"}, 32'(step_count), 32'(m_step));
    check({tag, ".win"},  32'(win_led), 32'(m_stat == 2));
    check({tag, ".lose"}, 32'(lose_led), 32'(m_stat == 3));
  endtask

  function automatic logic [11:0] tb_mask(input int k);
    logic [11:0] m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if ((c - k) * (c - k) <= 1) m[r * COLS + c] = 1'b1;
    return m;
  endfunction

  // Effect of one press on the model, at game level
  task automatic model_press(input logic [3:0] act, input logic rb);
    int k;
    if (m_stat == 1) begin
      if (rb) begin
        m_cur  = m_start;
        m_step = 0;
      end else if (act != 4'b0) begin
        k = 0;
        for (int i = 3; i >= 0; i--) if (act[i]) k = i;
        m_cur  = m_cur ^ tb_mask(k);
        m_step = (m_step >= SMAX) ? SMAX : m_step + 1;
        if (m_cur == 12'h0) m_stat = 2;
        else if (MAXS != 0 && m_step == MAXS) m_stat = 3;
      end
    end else if (m_stat >= 2 && rb) begin
      m_cur  = m_start;
      m_step = 0;
      m_stat = 1;
    end
  endtask

  task automatic press(input logic [3:0] act, input logic rb, input logic rnd, input int hold);
    @(negedge clk_d);
    act_bt = act; reset_bt = rb; random_bt = rnd;
    repeat (hold) @(negedge clk_d);
    act_bt = 4'b0; reset_bt = 1'b0; random_bt = 1'b0;
    repeat (4) @(negedge clk_d);
  endtask

  task automatic to_choose(input logic [4:0] sel);
    @(negedge clk_d);
    start_sw = 1'b0;
    board_num_sw = sel;
    repeat (4) @(negedge clk_d);
    m_stat = 0; m_step = 0; m_cur = rom[sel];
    check_all("choose");
    check("bsel", 32'(board_sel), 32'(sel));
    check("bled", 32'(board_num_led), 32'(sel));
  endtask

  task automatic do_start();
    @(negedge clk_d);
    start_sw = 1'b1;
    @(posedge clk_d); #1;
    check("start_led", 32'(start_led), 32'd1);
    repeat (4) @(negedge clk_d);
    m_start = m_cur; m_step = 0; m_stat = 1;
    check_all("start");
  endtask

  logic [11:0] exp_rnd;
  logic [3:0]  r_act;
  logic        r_rb, r_rnd;
  logic [4:0]  r_sel;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 12'($urandom);
    rom[0] = 12'h333; rom[1] = 12'h777; rom[3] = 12'h5A5;
    rom[5] = 12'h0F0; rom[6] = 12'h9C3;
    rst = 1'b1; board_num_sw = 5'd7; start_sw = 1'b1;
    reset_bt = 1'b0; act_bt = 4'b0; random_bt = 1'b0;
    m_cur = '0; m_start = '0; m_step = 0; m_stat = 0;
    repeat (2) @(posedge clk_d); #1;
    check_all("reset");
    check("reset.bsel", 32'(board_sel), 32'd0);
    check("reset.bled", 32'(board_num_led), 32'd0);
    check("reset.sled", 32'(start_led), 32'd0);
    @(negedge clk_d);
    start_sw = 1'b0; board_num_sw = 5'd0; rst = 1'b0;

    // Solve 12'h333 with act0 in one move
    to_choose(5'd0);
    do_start();
    press(4'b0001, 1'b0, 1'b0, 1); model_press(4'b0001, 1'b0); check_all("win1");

    // Exact latency and step-budget loss on 12'h777
    to_choose(5'd1);
    do_start();
    @(negedge clk_d); act_bt = 4'b1000;
    @(posedge clk_d);
    @(negedge clk_d); act_bt = 4'b0;
    @(posedge clk_d); @(posedge clk_d); #1;
    check("lat_n2.out", 32'(out), 32'h777);
    @(posedge clk_d); #1;
    check("lat_n3.out", 32'(out), 32'hBBB);
    check("lat_n3.step", 32'(step_count), 32'd1);
    check("lat_n3.stat", 32'(game_status), 32'd1);
    model_press(4'b1000, 1'b0);
    repeat (4) @(negedge clk_d);
    press(4'b1000, 1'b0, 1'b0, 1); model_press(4'b1000, 1'b0); check_all("lost");
    press(4'b0010, 1'b0, 1'b0, 2); model_press(4'b0010, 1'b0); check_all("lost_frz");
    press(4'b0000, 1'b1, 1'b0, 1); model_press(4'b0000, 1'b1); check_all("lost_rst");
    press(4'b0010, 1'b0, 1'b0, 1); model_press(4'b0010, 1'b0); check_all("win777");
    press(4'b0000, 1'b1, 1'b0, 1); model_press(4'b0000, 1'b1); check_all("won_rst");

    // Simultaneous pulses
    to_choose(5'd0);
    do_start();
    press(4'b0101, 1'b0, 1'b0, 1); model_press(4'b0101, 1'b0); check_all("multi");
    press(4'b0000, 1'b1, 1'b0, 1); model_press(4'b0000, 1'b1); check_all("multi_rst");
    press(4'b1000, 1'b0, 1'b0, 1); model_press(4'b1000, 1'b0); check_all("pre_rstact");
    press(4'b0010, 1'b1, 1'b0, 1); model_press(4'b0010, 1'b1); check_all("rst_act");

    // Random board in CHOOSE, held over ROM changes, released by board change
    to_choose(5'd5);
    @(negedge clk_d); random_bt = 1'b1;
    @(posedge clk_d);
    @(negedge clk_d); random_bt = 1'b0;
    @(posedge clk_d); @(posedge clk_d); #1;
    exp_rnd = tb_lfsr[11:0];
    if (exp_rnd == 12'h0) exp_rnd = 12'h001;
    @(posedge clk_d); #1;
    check("rnd.out", 32'(out), 32'(exp_rnd));
    rom[5] = ~rom[5];
    repeat (3) @(negedge clk_d);
    check("rnd.hold", 32'(out), 32'(exp_rnd));
    @(negedge clk_d); board_num_sw = 5'd6;
    @(posedge clk_d); #1;
    check("bsel_upd", 32'(board_sel), 32'd6);
    check("bsel_upd.out", 32'(out), 32'(exp_rnd));
    @(posedge clk_d); #1;
    check("bsel_rom", 32'(out), 32'(rom[6]));
    m_cur = rom[6];
    do_start();
    press(4'b0000, 1'b0, 1'b1, 1); check_all("rnd_play");

    // Long hold gives exactly one move
    to_choose(5'd3);
    do_start();
    press(4'b0100, 1'b0, 1'b0, 50); model_press(4'b0100, 1'b0); check_all("hold50");

    // Randomized games
    for (int g = 0; g < 25; g++) begin
      r_sel = 5'($urandom_range(7, 31));
      rom[r_sel] = 12'($urandom);
      to_choose(r_sel);
      do_start();
      for (int p = 0; p < int'($urandom_range(2, 6)); p++) begin
        r_act = 4'($urandom);
        r_rb  = ($urandom_range(0, 5) == 0);
        r_rnd = ($urandom_range(0, 7) == 0);
        press(r_act, r_rb, r_rnd, int'($urandom_range(1, 3)));
        model_press(r_act, r_rb);
        check_all("rand");
      end
    end

    // rst mid-game with a pulse in flight
    to_choose(5'd1);
    do_start();
    @(negedge clk_d); act_bt = 4'b0100;
    @(posedge clk_d); @(posedge clk_d);
    @(negedge clk_d); rst = 1'b1; start_sw = 1'b0; act_bt = 4'b0;
    @(posedge clk_d); #1;
    m_cur = '0; m_step = 0; m_stat = 0;
    check_all("midrst");
    check("midrst.bsel", 32'(board_sel), 32'd0);
    check("midrst.sled", 32'(start_led), 32'd0);
    @(negedge clk_d); rst = 1'b0;
    to_choose(5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/game_ctrl_core.md
# game_ctrl_core

Parametrised game controller for the board-flipping puzzle. It conditions the player buttons and loads a start board, either a preset or a random one. It then applies moves, counts steps and detects win or loss. It replaces the fixed 12-cell top controller: board size, action count and step limit are parameters, and it adds a loss state when the step budget runs out. It sits directly under the board top level and drives the cell LEDs and status LEDs.

## Interface
- ROWS, 3, board rows
- COLS, 4, board columns; also the number of action buttons
- BSEL_W, 5, width of the board-select switch bus
- STEP_W, 6, step counter width
- MAX_STEPS, 0, step budget; 0 = unlimited. Must be < 2^STEP_W.
- CELLS (local) = ROWS*COLS, must be ≤ 32. Cell (r,c) is bit r*COLS+c.

Ports:
- clk_d  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- board_num_sw  in  BSEL_W  preset board selector
- start_sw  in  1  level; high = play, low = return to board choice
- reset_bt  in  1  raw button: restart the current board
- act_bt  in  COLS  raw action buttons
- random_bt  in  1  raw button: random board
- preset_board  in  CELLS  board word returned combinationally by the external ROM for board_sel
- board_sel  out  BSEL_W  registered copy of board_num_sw, used as the ROM address
- out  out  CELLS  current board, 1 = lit
- game_status  out  2  0 CHOOSE, 1 PLAY, 2 WON, 3 LOST
- step_count  out  STEP_W  moves made since the last load
- win_led, lose_led  out  1  decodes of game_status
- board_num_led  out  BSEL_W  mirrors board_sel
- start_led  out  1  registered start_sw

## Operation
- Button conditioning (reset_bt, random_bt, each act_bt bit):
  - 2-FF synchroniser, then a rising-edge detector.
  - Produces one 1-cycle pulse per press, however long the button is held.
- LFSR: 32-bit Fibonacci, taps 32,22,2,1, seed 32'hACE1_0001. Free-running; never zero.
- Internal state: cur (CELLS), start_board (CELLS), step (STEP_W), rnd_hold (1), fsm state (3 bits).
- fsm state CHOOSE:
  - While rnd_hold = 0, cur <= preset_board every cycle.
  - A random pulse loads cur <= LFSR[CELLS-1:0] and sets rnd_hold. If that slice is zero, bit 0 is forced to 1.
  - Any change of board_sel clears rnd_hold.
  - step = 0.
  - start_led = 1 → INIT.
- fsm state INIT (1 cycle, game_status reports PLAY):
  - start_board <= cur, step <= 0.
  - → PLAY.
- fsm state PLAY:
  - An act pulse k applies cur <= cur ^ mask(k) and step <= step+1.
  - mask(k) sets every row's cells in columns k-1, k, k+1 that exist; there is no wrap.
  - If several act pulses arrive in the same cycle, only the lowest index is applied.
  - If the new cur is 0 → WON.
  - Otherwise, if MAX_STEPS ≠ 0 and the new step == MAX_STEPS → LOST.
  - With MAX_STEPS = 0, step saturates at all-ones.
  - A reset pulse restores cur <= start_board and step <= 0. If it coincides with an act pulse, reset wins and the act is dropped.
- fsm state WON / LOST:
  - cur and step are frozen.
  - Act pulses are ignored.
  - A reset pulse → INIT. INIT then reloads start_board from cur, so the board is restored first: the reset pulse also sets cur <= start_board.
- Global exits:
  - start_led = 0 in INIT, PLAY, WON or LOST → CHOOSE next cycle. rnd_hold is cleared and cur resumes tracking.
  - Random pulses outside CHOOSE are ignored.
  - rst overrides everything.

## Timing
- Reset values:
  - Outputs: out = 0, game_status = 0, step_count = 0, win_led = 0, lose_led = 0, board_sel = 0, board_num_led = 0, start_led = 0.
  - Internal: rnd_hold = 0, synchroniser flops = 0, LFSR = seed.
- Button latency: a press first sampled high at edge N produces a pulse in the cycle after edge N+2.
- The pulse is acted on at edge N+3: out, step_count and game_status all update at N+3.
- Win/loss is decided in the same edge as the move; there is no extra cycle.
- Start: start_sw high at edge N → start_led at N+1 → INIT at N+2 → PLAY at N+3.
- Board select: board_sel is registered at edge N. In CHOOSE, out reflects the ROM word at N+1.
- rst is asserted mid-game → everything returns to reset values at the next edge, and pending pulses are discarded.

## Test plan
- Default params, preset_board = 12'h333, start, one press of act0 → out = 0, step_count = 1, game_status = 2, win_led = 1.
- MAX_STEPS = 2, preset_board = 12'h777, act3 pressed twice → out 12'hBBB then 12'h777, step_count = 2, game_status = 3. A further act press changes nothing.
- In PLAY from 12'h777: act1 → 12'h000 → WON. Then reset_bt → next status PLAY, out = 12'h777, step_count = 0.
- act0 and act2 pressed in the same cycle on 12'h333 → only act0 is applied, out = 0. Separately, reset_bt with act1 in the same cycle → out = start_board, step_count = 0.
- Random in CHOOSE → out = LFSR slice, held while preset_board changes. Toggling board_num_sw → out = new preset one cycle after board_sel updates.
- Hold act2 for 50 cycles → exactly one move. Assert rst in PLAY → all outputs 0 and game_status 0 on the next edge.
